// File: rtl/pc_ras_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_ras_unit_pkg: shared defines and RAS operation encoding          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package pc_ras_unit_pkg;

  localparam logic        RST_ENABLE       = 1'b0;
  localparam int          INST_ADDR_LENGTH = 16;
  localparam logic [15:0] ZERO16           = 16'h0000;

  typedef enum logic [2:0] {
    RAS_NOP     = 3'd0,
    RAS_PUSH    = 3'd1,
    RAS_POP     = 3'd2,
    RAS_REPLACE = 3'd3,
    RAS_CLEAR   = 3'd4
  } ras_op_e;

endpackage
`default_nettype wire

// File: rtl/pc_ras_unit_ras_stack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ras_stack: circular return-address stack, oldest entry overwritten  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module ras_stack
  import pc_ras_unit_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  ras_op_e          i_op,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_sp;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_top_idx;

  // r_sp points at the next free slot; the top sits one below it.
  assign w_top_idx = r_sp - PTR_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i == RST_ENABLE) begin
      r_sp    <= '0;
      r_count <= '0;
    end else begin
      case (i_op)
        RAS_PUSH: begin
          r_sp <= r_sp + PTR_W'(1);
          if (r_count != c_full) r_count <= r_count + CNT_W'(1);
        end
        RAS_POP: begin
          r_sp <= w_top_idx;
          if (r_count != '0) r_count <= r_count - CNT_W'(1);
        end
        RAS_CLEAR: begin
          r_sp    <= '0;
          r_count <= '0;
        end
        default: ;
      endcase
    end
  end

  // Entry storage is unreset; writes are still suppressed during reset.
  always_ff @(posedge clk_i) begin
    if (rst_i != RST_ENABLE) begin
      if (i_op == RAS_PUSH)         r_mem[r_sp]      <= i_data;
      else if (i_op == RAS_REPLACE) r_mem[w_top_idx] <= i_data;
    end
  end

  assign o_top   = r_mem[w_top_idx];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pc_ras_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_ras_unit: fetch PC generator with hold/flush/ret/redirect and RAS |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module pc_ras_unit
  import pc_ras_unit_pkg::*;
#(
  parameter int                ADDR_W    = INST_ADDR_LENGTH,
  parameter int unsigned       STEP      = 1,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(ZERO16),
  parameter logic [ADDR_W-1:0] FLUSH_VEC = ADDR_W'(ZERO16),
  parameter int                RAS_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [5:0]                   stall_i,
  input  logic                         pcNewFlag_i,
  input  logic [ADDR_W-1:0]            PC_i,
  input  logic                         call_i,
  input  logic                         ret_i,
  output logic [ADDR_W-1:0]            PC_o,
  output logic [$clog2(RAS_DEPTH):0]   ras_count_o,
  output logic                         ras_underflow_o
);

  localparam logic [ADDR_W-1:0] c_step = ADDR_W'(STEP);

  logic [ADDR_W-1:0]          r_pc;
  logic                       r_underflow;
  logic [ADDR_W-1:0]          w_pc_next;
  logic [ADDR_W-1:0]          w_pc_inc;
  logic                       w_uf_next;
  logic                       w_hold;
  logic                       w_flush;
  logic                       w_empty;
  ras_op_e                    w_op;
  logic [ADDR_W-1:0]          w_top;
  logic [$clog2(RAS_DEPTH):0] w_count;
  logic                       w_unused_stall;

  assign w_unused_stall = ^stall_i[3:0];
  assign w_hold   = stall_i[5] & stall_i[4];
  assign w_flush  = stall_i[5] & ~stall_i[4];
  assign w_pc_inc = r_pc + c_step;
  assign w_empty  = (w_count == '0);

  always_comb begin
    w_pc_next = w_pc_inc;
    w_uf_next = 1'b0;
    w_op      = RAS_NOP;
    if (w_hold) begin
      w_pc_next = r_pc;
    end else if (w_flush) begin
      w_pc_next = FLUSH_VEC;
      w_op      = RAS_CLEAR;
    end else if (ret_i) begin
      if (pcNewFlag_i && call_i) begin
        // Tail call: swap the return target in place; an empty stack just takes a push.
        w_pc_next = PC_i;
        w_op      = w_empty ? RAS_PUSH : RAS_REPLACE;
      end else if (!w_empty) begin
        w_pc_next = w_top;
        w_op      = RAS_POP;
      end else begin
        w_uf_next = 1'b1;
      end
    end else if (pcNewFlag_i) begin
      w_pc_next = PC_i;
      if (call_i) w_op = RAS_PUSH;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i == RST_ENABLE) begin
      r_pc        <= RESET_VEC;
      r_underflow <= 1'b0;
    end else begin
      r_pc        <= w_pc_next;
      r_underflow <= w_uf_next;
    end
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_W)
  ) u_ras_stack (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_op    (w_op),
    .i_data  (w_pc_inc),
    .o_top   (w_top),
    .o_count (w_count)
  );

  assign PC_o            = r_pc;
  assign ras_count_o     = w_count;
  assign ras_underflow_o = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_pc_ras_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pc_ras_unit: vector table plus hand sequences, queued expectations|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_pc_ras_unit;

  localparam logic [15:0] c_flush_vec = 16'h0A00;

  typedef struct {
    logic        rst_n;
    logic [5:0]  stall;
    logic        nf;
    logic [15:0] pc;
    logic        call;
    logic        ret;
    logic [15:0] e_pc;
    logic [2:0]  e_cnt;
    logic        e_uf;
  } vec_t;

  typedef struct {
    logic [15:0] pc;
    logic [2:0]  cnt;
    logic        uf;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [5:0]  stall_i;
  logic        pcNewFlag_i;
  logic [15:0] PC_i;
  logic        call_i;
  logic        ret_i;
  logic [15:0] PC_o;
  logic [2:0]  ras_count_o;
  logic        ras_underflow_o;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk_i = ~clk_i;

  pc_ras_unit #(
    .ADDR_W    (16),
    .STEP      (1),
    .RESET_VEC (16'h0000),
    .FLUSH_VEC (c_flush_vec),
    .RAS_DEPTH (4)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .stall_i         (stall_i),
    .pcNewFlag_i     (pcNewFlag_i),
    .PC_i            (PC_i),
    .call_i          (call_i),
    .ret_i           (ret_i),
    .PC_o            (PC_o),
    .ras_count_o     (ras_count_o),
    .ras_underflow_o (ras_underflow_o)
  );

  task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got 0x%04h, expected 0x%04h", name, idx, act, exp);
  endtask

  task automatic add(input logic rst_n, input logic [5:0] stall, input logic nf, input logic [15:0] pc,
                     input logic call, input logic ret,
                     input logic [15:0] e_pc, input logic [2:0] e_cnt, input logic e_uf);
    vec_t v;
    v.rst_n = rst_n; v.stall = stall; v.nf = nf; v.pc = pc; v.call = call; v.ret = ret;
    v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_uf = e_uf;
    vecs.push_back(v);
  endtask

  // Drive one cycle, queue its expectation, and compare just after the edge.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    rst_i = v.rst_n; stall_i = v.stall; pcNewFlag_i = v.nf; PC_i = v.pc;
    call_i = v.call; ret_i = v.ret;
    e.pc = v.e_pc; e.cnt = v.e_cnt; e.uf = v.e_uf;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard step %0d: queue empty, expected one entry", idx);
    end else begin
      got = sb.pop_front();
      check("PC_o", idx, PC_o, got.pc);
      check("ras_count_o", idx, {13'd0, ras_count_o}, {13'd0, got.cnt});
      check("ras_underflow_o", idx, {15'd0, ras_underflow_o}, {15'd0, got.uf});
    end
  endtask

  task automatic step(input logic rst_n, input logic [5:0] stall, input logic nf, input logic [15:0] pc,
                      input logic call, input logic ret,
                      input logic [15:0] e_pc, input logic [2:0] e_cnt, input logic e_uf, input int idx);
    vec_t v;
    v.rst_n = rst_n; v.stall = stall; v.nf = nf; v.pc = pc; v.call = call; v.ret = ret;
    v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_uf = e_uf;
    apply(v, idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; stall_i = '0; pcNewFlag_i = 1'b0; PC_i = '0; call_i = 1'b0; ret_i = 1'b0;
    #1;
    //   rst  stall      nf pc       call ret  e_pc     cnt uf
    add(0, 6'b000000, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);  // reset
    add(1, 6'b000000, 0, 16'h0000, 0, 0, 16'h0001, 0, 0);
    add(1, 6'b000000, 0, 16'h0000, 0, 0, 16'h0002, 0, 0);
    add(1, 6'b000000, 0, 16'h0000, 0, 0, 16'h0003, 0, 0);
    add(1, 6'b000000, 1, 16'h0010, 0, 0, 16'h0010, 0, 0);
    add(1, 6'b000000, 1, 16'h0100, 1, 0, 16'h0100, 1, 0);  // call, push 0x11
    add(1, 6'b000000, 0, 16'h0000, 0, 0, 16'h0101, 1, 0);
    add(1, 6'b000000, 0, 16'h0000, 0, 0, 16'h0102, 1, 0);
    add(1, 6'b000000, 0, 16'h0000, 0, 1, 16'h0011, 0, 0);  // ret
    add(1, 6'b000000, 0, 16'h0000, 0, 1, 16'h0012, 0, 1);  // ret on empty
    add(1, 6'b000000, 0, 16'h0000, 0, 0, 16'h0013, 0, 0);
    add(1, 6'b000000, 1, 16'h0010, 0, 0, 16'h0010, 0, 0);
    add(1, 6'b000000, 1, 16'h0020, 1, 0, 16'h0020, 1, 0);  // push 0x11
    add(1, 6'b000000, 1, 16'h0030, 1, 0, 16'h0030, 2, 0);  // push 0x21
    add(1, 6'b000000, 1, 16'h0040, 1, 0, 16'h0040, 3, 0);  // push 0x31
    add(1, 6'b000000, 1, 16'h0050, 1, 0, 16'h0050, 4, 0);  // push 0x41
    add(1, 6'b000000, 1, 16'h0060, 1, 0, 16'h0060, 4, 0);  // push 0x51 over 0x11
    add(1, 6'b000000, 0, 16'h0000, 0, 1, 16'h0051, 3, 0);
    add(1, 6'b000000, 0, 16'h0000, 0, 1, 16'h0041, 2, 0);
    add(1, 6'b000000, 0, 16'h0000, 0, 1, 16'h0031, 1, 0);
    add(1, 6'b000000, 1, 16'h0999, 0, 1, 16'h0021, 0, 0);  // ret with redirect, PC_i ignored
    add(1, 6'b000000, 0, 16'h0000, 0, 1, 16'h0022, 0, 1);
    add(1, 6'b000000, 0, 16'h0000, 0, 0, 16'h0023, 0, 0);
    add(1, 6'b000000, 1, 16'h0200, 1, 0, 16'h0200, 1, 0);  // push 0x24
    add(1, 6'b110000, 1, 16'h0300, 1, 0, 16'h0200, 1, 0);  // hold
    add(1, 6'b110000, 1, 16'h0300, 1, 0, 16'h0200, 1, 0);
    add(1, 6'b110000, 1, 16'h0300, 1, 1, 16'h0200, 1, 0);
    add(1, 6'b100000, 0, 16'h0000, 0, 1, c_flush_vec, 0, 0);  // flush beats ret
    add(1, 6'b000000, 0, 16'h0000, 0, 1, 16'h0A01, 0, 1);
    add(1, 6'b000000, 1, 16'h0400, 1, 1, 16'h0400, 1, 0);  // ret+call on empty: push 0x0A02
    add(1, 6'b000000, 1, 16'h0500, 1, 1, 16'h0500, 1, 0);  // ret+call: replace with 0x401
    add(1, 6'b000000, 1, 16'h0777, 0, 1, 16'h0401, 0, 0);
    add(1, 6'b000000, 0, 16'h0900, 1, 0, 16'h0402, 0, 0);  // call without redirect
    add(1, 6'b000000, 1, 16'hFFFF, 0, 0, 16'hFFFF, 0, 0);
    add(1, 6'b000000, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);  // wrap
    add(1, 6'b000000, 1, 16'hFFFF, 0, 0, 16'hFFFF, 0, 0);
    add(1, 6'b000000, 1, 16'h1234, 1, 0, 16'h1234, 1, 0);  // push wrapped 0x0000
    add(1, 6'b000000, 0, 16'h0000, 0, 1, 16'h0000, 0, 0);
    add(1, 6'b000000, 1, 16'h0100, 1, 0, 16'h0100, 1, 0);  // push 0x0001
    add(1, 6'b000000, 1, 16'h0200, 1, 0, 16'h0200, 2, 0);  // push 0x0101
    add(0, 6'b000000, 0, 16'h0000, 0, 1, 16'h0000, 0, 0);  // reset during ret
    add(1, 6'b000000, 0, 16'h0000, 0, 1, 16'h0001, 0, 1);
    add(1, 6'b000000, 0, 16'h0000, 0, 0, 16'h0002, 0, 0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Underflow pulse must drop during a following hold, with PC frozen.
    step(1, 6'b000000, 0, 16'h0000, 0, 1, 16'h0003, 0, 1, 100);
    step(1, 6'b110000, 0, 16'h0000, 0, 1, 16'h0003, 0, 0, 101);
    // Hold must not disturb a live stack entry.
    step(1, 6'b000000, 1, 16'h0040, 1, 0, 16'h0040, 1, 0, 102);
    step(1, 6'b111111, 1, 16'h0070, 1, 1, 16'h0040, 1, 0, 103);
    step(1, 6'b001111, 0, 16'h0000, 0, 1, 16'h0004, 0, 0, 104);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
